// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: multi-channel LED pattern generator.
// Each channel is set at run time to OFF, ON, BLINK or BURST. Half-periods
// are counted in ticks from one shared free-running prescaler.
// Optional feature: define LED_PATTERN_PWM_EN to add a global brightness
// PWM stage on the LED outputs. Without it, brightness is ignored.
module led_pattern_ctrl #(
  parameter logic [31:0] CLOCK_FREQUENCY = 32'd33_000_000,
  parameter logic [31:0] TICK_HZ         = 32'd1000,
  parameter int          NUM_CH          = 4,
  parameter int          HALF_W          = 16,
  parameter int          CNT_W           = 4,
  parameter int          GAP_HALVES      = 4,
  localparam int         CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [HALF_W-1:0] cfg_half,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [3:0]        brightness,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] burst_wrap
);

  // Handshake: cfg_we is a single-cycle write strobe with no back-pressure.
  // A write is always accepted in the cycle it is seen, and it targets
  // channel cfg_ch. A cfg_ch value with no matching channel selects nothing,
  // so the write is dropped.

  localparam logic [31:0] TICK_DIV   = CLOCK_FREQUENCY / TICK_HZ;
  localparam int          PSC_W      = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_RELOAD = PSC_W'(TICK_DIV - 32'd1);
  // The gap length is GAP_HALVES*half. It is held three bits wider than half,
  // so the product cannot wrap.
  localparam int          GAP_W      = HALF_W + 3;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_GAP    = 1'b1
  } st_e;

  // Prescaler
  logic [PSC_W-1:0] psc_q;
  logic             tick;

  assign tick = (psc_q == '0);

  // Free-running down-counter. Configuration writes never restart it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= '0;
    end else if (tick) begin
      psc_q <= PSC_RELOAD;
    end else begin
      psc_q <= psc_q - PSC_W'(1);
    end
  end

  // Per-channel state
  mode_e             mode_q  [NUM_CH];
  mode_e             mode_d  [NUM_CH];
  logic [HALF_W-1:0] half_q  [NUM_CH];
  logic [HALF_W-1:0] half_d  [NUM_CH];
  logic [CNT_W-1:0]  count_q [NUM_CH];
  logic [CNT_W-1:0]  count_d [NUM_CH];
  logic [HALF_W-1:0] hcnt_q  [NUM_CH];
  logic [HALF_W-1:0] hcnt_d  [NUM_CH];
  logic [CNT_W-1:0]  bcnt_q  [NUM_CH];
  logic [CNT_W-1:0]  bcnt_d  [NUM_CH];
  logic [GAP_W-1:0]  gcnt_q  [NUM_CH];
  logic [GAP_W-1:0]  gcnt_d  [NUM_CH];
  logic [GAP_W-1:0]  gap_len [NUM_CH];
  logic              ph_q    [NUM_CH];
  logic              ph_d    [NUM_CH];
  st_e               st_q    [NUM_CH];
  st_e               st_d    [NUM_CH];

  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] lit_d;
  logic [NUM_CH-1:0] wrap_d;
  logic [NUM_CH-1:0] led_d;
  logic [NUM_CH-1:0] led_q;
  logic [NUM_CH-1:0] wrap_q;
  logic              pwm_on;

  // Decode the write strobe into one select bit per channel.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  // Next-state logic for every channel. The lit value is taken from the
  // next state, so the registered led follows its cause by one clock.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i]  = mode_q[i];
      half_d[i]  = half_q[i];
      count_d[i] = count_q[i];
      hcnt_d[i]  = hcnt_q[i];
      bcnt_d[i]  = bcnt_q[i];
      gcnt_d[i]  = gcnt_q[i];
      ph_d[i]    = ph_q[i];
      st_d[i]    = st_q[i];
      wrap_d[i]  = 1'b0;
      lit_d[i]   = 1'b0;
      gap_len[i] = GAP_W'(GAP_HALVES) * GAP_W'(half_q[i]);

      if (wr_sel[i]) begin
        // A write beats a same-cycle tick on this channel.
        mode_d[i]  = mode_e'(cfg_mode);
        half_d[i]  = (cfg_half == '0) ? HALF_W'(1) : cfg_half;
        count_d[i] = cfg_count;
        hcnt_d[i]  = '0;
        bcnt_d[i]  = '0;
        gcnt_d[i]  = '0;
        ph_d[i]    = 1'b1;
        st_d[i]    = ST_ACTIVE;
      end else begin
        unique case (mode_q[i])
          MODE_OFF: begin
            hcnt_d[i] = '0;
            bcnt_d[i] = '0;
            gcnt_d[i] = '0;
          end
          MODE_ON: begin
          end
          MODE_BLINK: begin
            if (tick) begin
              if (hcnt_q[i] == half_q[i] - HALF_W'(1)) begin
                hcnt_d[i] = '0;
                ph_d[i]   = ~ph_q[i];
              end else begin
                hcnt_d[i] = hcnt_q[i] + HALF_W'(1);
              end
            end
          end
          MODE_BURST: begin
            if (count_q[i] == '0) begin
              // A zero-length burst is treated as permanently off.
              hcnt_d[i] = '0;
              bcnt_d[i] = '0;
              gcnt_d[i] = '0;
            end else if (st_q[i] == ST_ACTIVE) begin
              if (tick) begin
                if (hcnt_q[i] == half_q[i] - HALF_W'(1)) begin
                  hcnt_d[i] = '0;
                  if (!ph_q[i]) begin
                    // This toggle ends an off-phase and completes one blink.
                    bcnt_d[i] = bcnt_q[i] + CNT_W'(1);
                    if (bcnt_q[i] + CNT_W'(1) == count_q[i]) begin
                      st_d[i]   = ST_GAP;
                      ph_d[i]   = 1'b0;
                      gcnt_d[i] = '0;
                    end else begin
                      ph_d[i] = 1'b1;
                    end
                  end else begin
                    ph_d[i] = 1'b0;
                  end
                end else begin
                  hcnt_d[i] = hcnt_q[i] + HALF_W'(1);
                end
              end
            end else begin
              if (tick) begin
                if (gcnt_q[i] + GAP_W'(1) >= gap_len[i]) begin
                  gcnt_d[i] = '0;
                  hcnt_d[i] = '0;
                  bcnt_d[i] = '0;
                  ph_d[i]   = 1'b1;
                  st_d[i]   = ST_ACTIVE;
                  wrap_d[i] = 1'b1;
                end else begin
                  gcnt_d[i] = gcnt_q[i] + GAP_W'(1);
                end
              end
            end
          end
        endcase
      end

      unique case (mode_d[i])
        MODE_OFF:   lit_d[i] = 1'b0;
        MODE_ON:    lit_d[i] = 1'b1;
        MODE_BLINK: lit_d[i] = ph_d[i];
        MODE_BURST: lit_d[i] = (count_d[i] != '0) && (st_d[i] == ST_ACTIVE) && ph_d[i];
      endcase
    end
  end

  // Per-channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]  <= MODE_OFF;
        half_q[i]  <= '0;
        count_q[i] <= '0;
        hcnt_q[i]  <= '0;
        bcnt_q[i]  <= '0;
        gcnt_q[i]  <= '0;
        ph_q[i]    <= 1'b0;
        st_q[i]    <= ST_ACTIVE;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]  <= mode_d[i];
        half_q[i]  <= half_d[i];
        count_q[i] <= count_d[i];
        hcnt_q[i]  <= hcnt_d[i];
        bcnt_q[i]  <= bcnt_d[i];
        gcnt_q[i]  <= gcnt_d[i];
        ph_q[i]    <= ph_d[i];
        st_q[i]    <= st_d[i];
      end
    end
  end

`ifdef LED_PATTERN_PWM_EN
  logic [3:0] pwm_q;

  // Free-running duty counter; led is enabled for brightness+1 of 16 counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= 4'd0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
    end
  end

  assign pwm_on = (pwm_q <= brightness);
`else
  logic unused_brightness;

  assign unused_brightness = ^brightness;
  assign pwm_on            = 1'b1;
`endif

  assign led_d = lit_d & {NUM_CH{pwm_on}};

  // Registered LED drive and burst-wrap pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= '0;
      wrap_q <= '0;
    end else begin
      led_q  <= led_d;
      wrap_q <= wrap_d;
    end
  end

  assign led        = led_q;
  assign burst_wrap = wrap_q;

endmodule
